// File: rtl/orient_scan_pkg.sv
// Orientation scan package: shared types and the orientation decode.
//   orient_e     : 3-bit orientation code (0..315 degrees in 45-degree steps)
//   state_e      : scan controller FSM states
//   orient_cfg_t : per-orientation axis directions and major-axis select
//   orient_cfg() : maps an orientation code to its axis configuration
package orient_scan_pkg;

  typedef enum logic [2:0] {
    O0   = 3'd0,
    O45  = 3'd1,
    O90  = 3'd2,
    O135 = 3'd3,
    O180 = 3'd4,
    O225 = 3'd5,
    O270 = 3'd6,
    O315 = 3'd7
  } orient_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    FIN  = 2'd3
  } state_e;

  typedef struct packed {
    logic x_down;
    logic y_down;
    logic col_major;  // 1: y is the fast (minor) axis
  } orient_cfg_t;

  function automatic orient_cfg_t orient_cfg(input orient_e o);
    orient_cfg_t c;
    c = '0;
    case (o)
      O0:      c = '{x_down: 1'b0, y_down: 1'b0, col_major: 1'b0};
      O45:     c = '{x_down: 1'b0, y_down: 1'b0, col_major: 1'b1};
      O90:     c = '{x_down: 1'b0, y_down: 1'b1, col_major: 1'b1};
      O135:    c = '{x_down: 1'b1, y_down: 1'b0, col_major: 1'b0};
      O180:    c = '{x_down: 1'b1, y_down: 1'b1, col_major: 1'b0};
      O225:    c = '{x_down: 1'b1, y_down: 1'b1, col_major: 1'b1};
      O270:    c = '{x_down: 1'b1, y_down: 1'b0, col_major: 1'b1};
      O315:    c = '{x_down: 1'b0, y_down: 1'b1, col_major: 1'b0};
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/scan_axis_cnt.sv
// Up/down axis counter with explicit terminal compare (never wraps modulo 2**CNT_W).
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   clear      : load start value (max_val when counting down, else 0)
//   enable     : step one in the selected direction; at terminal, reload start value
//   down       : count direction
//   max_val    : highest coordinate on this axis
//   count      : current value
//   at_term    : count is at the terminal value for the current direction
module scan_axis_cnt #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             down,
  input  logic [CNT_W-1:0] max_val,
  output logic [CNT_W-1:0] count,
  output logic             at_term
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_start;

  assign w_start = down ? max_val : '0;
  assign at_term = down ? (r_count == '0) : (r_count == max_val);
  assign count   = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= w_start;
    end else if (enable) begin
      if (at_term) begin
        r_count <= w_start;
      end else if (down) begin
        r_count <= r_count - ONE;
      end else begin
        r_count <= r_count + ONE;
      end
    end
  end

endmodule

// File: rtl/orient_scan_ctrl.sv
// Orientation-aware frame scan controller. Walks an IMG_W x IMG_H frame in the
// direction and major axis chosen by the orientation latched at start, emitting
// one (x, y) coordinate per valid/ready handshake.
//   clk, reset           : clock, synchronous active-high reset
//   start, orient, abort : frame control (start/orient sampled in IDLE only)
//   busy, done           : busy LOAD..FIN, done pulses in FIN
//   addr_valid/ready     : coordinate handshake
//   x, y                 : coordinate
//   line_last/frame_last : last of minor-axis line / last of frame
module orient_scan_ctrl
  import orient_scan_pkg::*;
#(
  parameter int CNT_W = 10,
  parameter int IMG_W = 1024,
  parameter int IMG_H = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       orient,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             addr_valid,
  input  logic             addr_ready,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_last,
  output logic             frame_last
);

  localparam logic [CNT_W-1:0] X_MAX = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(IMG_H - 1);

  state_e      r_state;
  state_e      w_state_nxt;
  orient_e     r_orient;
  orient_cfg_t w_cfg;

  logic w_clear;
  logic w_hs;
  logic w_x_term, w_y_term;
  logic w_minor_term, w_major_term;
  logic w_step_minor, w_step_major;
  logic w_x_en, w_y_en;

  assign w_cfg = orient_cfg(r_orient);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_orient <= O0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && start && !abort) begin
        r_orient <= orient_e'(orient);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    addr_valid  = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !abort) w_state_nxt = LOAD;
      end
      LOAD: begin
        busy        = 1'b1;
        w_clear     = 1'b1;
        w_state_nxt = abort ? IDLE : SCAN;
      end
      SCAN: begin
        busy       = 1'b1;
        addr_valid = 1'b1;
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (addr_ready && frame_last) begin
          w_state_nxt = FIN;
        end
      end
      FIN: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Abort blocks the handshake so the counters never step on an aborting cycle.
  assign w_hs         = addr_valid && addr_ready && !abort;
  assign w_minor_term = w_cfg.col_major ? w_y_term : w_x_term;
  assign w_major_term = w_cfg.col_major ? w_x_term : w_y_term;

  // Flags are gated by addr_valid so they read low outside SCAN.
  assign line_last    = addr_valid && w_minor_term;
  assign frame_last   = line_last && w_major_term;

  // The final handshake leaves the counters parked on the last coordinate.
  assign w_step_minor = w_hs && !frame_last;
  assign w_step_major = w_step_minor && w_minor_term;
  assign w_x_en       = w_cfg.col_major ? w_step_major : w_step_minor;
  assign w_y_en       = w_cfg.col_major ? w_step_minor : w_step_major;

  scan_axis_cnt #(
    .CNT_W (CNT_W)
  ) u_x_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_clear),
    .enable  (w_x_en),
    .down    (w_cfg.x_down),
    .max_val (X_MAX),
    .count   (x),
    .at_term (w_x_term)
  );

  scan_axis_cnt #(
    .CNT_W (CNT_W)
  ) u_y_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_clear),
    .enable  (w_y_en),
    .down    (w_cfg.y_down),
    .max_val (Y_MAX),
    .count   (y),
    .at_term (w_y_term)
  );

endmodule

// File: tb/tb_orient_scan_ctrl.sv
// Self-checking bench for orient_scan_ctrl with a 4x3 frame.
module tb_orient_scan_ctrl;

  localparam int CNT_W = 10;
  localparam int W     = 4;
  localparam int H     = 3;
  localparam int N     = W * H;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       orient;
  logic             abort;
  logic             busy;
  logic             done;
  logic             addr_valid;
  logic             addr_ready;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             line_last;
  logic             frame_last;

  int checks = 0;
  int errors = 0;

  // Orientation table: bit i belongs to orientation code i.
  logic [7:0] xdn_tbl = 8'b0111_1000;
  logic [7:0] ydn_tbl = 8'b1011_0100;
  logic [7:0] col_tbl = 8'b0110_0110;

  orient_scan_ctrl #(
    .CNT_W (CNT_W),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .orient     (orient),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .x          (x),
    .y          (y),
    .line_last  (line_last),
    .frame_last (frame_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // k-th coordinate of the frame for orientation o, straight from the orientation table.
  task automatic ref_coord(input int o, input int k, output int ex, output int ey,
                           output int ell, output int efl);
    int xi, yi;
    if (col_tbl[o]) begin
      yi  = k % H;
      xi  = k / H;
      ell = (yi == H - 1) ? 1 : 0;
    end else begin
      xi  = k % W;
      yi  = k / W;
      ell = (xi == W - 1) ? 1 : 0;
    end
    ex  = xdn_tbl[o] ? (W - 1 - xi) : xi;
    ey  = ydn_tbl[o] ? (H - 1 - yi) : yi;
    efl = (k == N - 1) ? 1 : 0;
  endtask

  // mode 0: always ready; 1: random ready; 2: three stall cycles on the 2nd coordinate.
  // abort_at >= 0 aborts while that coordinate is presented. noise drives start/orient in SCAN.
  task automatic run_frame(input int o, input int mode, input int abort_at, input bit noise);
    int k, cyc, stalls, ex, ey, ell, efl;
    bit rdy;
    k = 0; cyc = 0; stalls = 0;
    start = 1'b1; orient = 3'(o);
    step(); cyc = 1;
    start = 1'b0;
    check($sformatf("o%0d_load_busy", o), 32'(busy), 1);
    check($sformatf("o%0d_load_valid", o), 32'(addr_valid), 0);
    while (k < N && cyc < 4 * N + 20) begin
      step(); cyc++;
      ref_coord(o, k, ex, ey, ell, efl);
      check($sformatf("o%0d_k%0d_valid", o, k), 32'(addr_valid), 1);
      check($sformatf("o%0d_k%0d_x", o, k), 32'(x), 32'(ex));
      check($sformatf("o%0d_k%0d_y", o, k), 32'(y), 32'(ey));
      check($sformatf("o%0d_k%0d_line_last", o, k), 32'(line_last), 32'(ell));
      check($sformatf("o%0d_k%0d_frame_last", o, k), 32'(frame_last), 32'(efl));
      if (k == abort_at) begin
        abort = 1'b1; addr_ready = 1'b1;
        step();
        abort = 1'b0; addr_ready = 1'b0;
        check("abort_valid", 32'(addr_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        for (int i = 0; i < 3; i++) begin
          step();
          check("abort_no_done", 32'(done), 0);
          check("abort_idle_busy", 32'(busy), 0);
        end
        return;
      end
      if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
      else if (mode == 2) rdy = !(k == 1 && stalls < 3);
      else rdy = 1'b1;
      if (!rdy) stalls++;
      addr_ready = rdy;
      if (noise) begin
        start  = 1'b1;
        orient = 3'($urandom_range(0, 7));
      end
      if (rdy) k++;
    end
    check($sformatf("o%0d_handshakes", o), 32'(k), 32'(N));
    step(); cyc++;
    start = 1'b0; addr_ready = 1'b0;
    check($sformatf("o%0d_fin_done", o), 32'(done), 1);
    check($sformatf("o%0d_fin_busy", o), 32'(busy), 1);
    check($sformatf("o%0d_fin_valid", o), 32'(addr_valid), 0);
    check($sformatf("o%0d_done_cycle", o), 32'(cyc), 32'(N + 2 + stalls));
    step();
    check($sformatf("o%0d_idle_busy", o), 32'(busy), 0);
    check($sformatf("o%0d_idle_done", o), 32'(done), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; orient = 3'd0; abort = 1'b0; addr_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(addr_valid), 0);
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_line_last", 32'(line_last), 0);
    check("rst_frame_last", 32'(frame_last), 0);

    // Directed frames from the test plan.
    run_frame(0, 0, -1, 1'b0);
    run_frame(4, 0, -1, 1'b0);
    run_frame(5, 0, -1, 1'b0);
    run_frame(0, 2, -1, 1'b0);

    // Abort at the 5th coordinate, then a clean restart from (0,2).
    run_frame(2, 0, 4, 1'b0);
    run_frame(2, 0, -1, 1'b0);

    // start held high during the scan must not disturb it.
    run_frame(3, 0, -1, 1'b1);

    // start together with abort in IDLE stays IDLE.
    start = 1'b1; abort = 1'b1; orient = 3'd1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 0);
    step();
    check("start_abort_busy2", 32'(busy), 0);
    check("start_abort_valid", 32'(addr_valid), 0);

    // Randomized backpressure across every orientation.
    for (int o = 0; o < 8; o++) run_frame(o, 1, -1, 1'b0);
    for (int r = 0; r < 4; r++) run_frame(int'($urandom_range(0, 7)), 1, -1, 1'b0);

    // Reset in the middle of a scan.
    start = 1'b1; orient = 3'd4; addr_ready = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check("pre_reset_valid", 32'(addr_valid), 1);
    reset = 1'b1;
    step();
    check("mid_rst_x", 32'(x), 0);
    check("mid_rst_y", 32'(y), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_valid", 32'(addr_valid), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_line_last", 32'(line_last), 0);
    check("mid_rst_frame_last", 32'(frame_last), 0);
    reset = 1'b0; addr_ready = 1'b0;
    step();
    run_frame(6, 0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/orient_scan_ctrl.md
Name: orient_scan_ctrl

Overview:
- Sequences the pixel-coordinate counters for one image frame according to the selected orientation.
- Produces an (x, y) coordinate stream with a valid/ready handshake, walking the frame in the direction and major axis that the orientation selects.
- Sits between the frame-level control (start/abort) and the memory address datapath.
- Owns the up/down axis counters that were previously instantiated per orientation.

Parameters:
- CNT_W, 10, width of each axis counter and of the x/y outputs.
- IMG_W, 1024, frame width in pixels; legal range 2..2**CNT_W.
- IMG_H, 1024, frame height in pixels; legal range 2..2**CNT_W.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  begin a frame scan; sampled only in IDLE
- orient  in  3  orientation code, latched on accepted start
- abort  in  1  terminate the scan in progress
- busy  out  1  high from the cycle after an accepted start until return to IDLE
- done  out  1  one-cycle pulse after the final coordinate handshake
- addr_valid  out  1  coordinate on x/y is valid
- addr_ready  in  1  downstream accepts the coordinate
- x  out  CNT_W  column coordinate
- y  out  CNT_W  row coordinate
- line_last  out  1  current coordinate is the last of its minor-axis line
- frame_last  out  1  current coordinate is the last of the frame

Behaviour:
- Reset values: state IDLE; busy=0, done=0, addr_valid=0, line_last=0, frame_last=0; x=0, y=0; latched orient=0.
- Orientation table, giving x direction, y direction and major axis:
  - 0 (0°): x up, y up, row-major.
  - 1 (45°): x up, y up, column-major.
  - 2 (90°): x up, y down, column-major.
  - 3 (135°): x down, y up, row-major.
  - 4 (180°): x down, y down, row-major.
  - 5 (225°): x down, y down, column-major.
  - 6 (270°): x down, y up, column-major.
  - 7 (315°): x up, y down, row-major.
- Start values per axis: an "up" axis starts at 0; a "down" axis starts at IMG_W-1 (x) or IMG_H-1 (y).
- Axis order: row-major means x is the minor (fast) axis; column-major means y is the minor axis.
- FSM states: IDLE, LOAD, SCAN, FIN.
- IDLE:
  - start=1 latches orient and moves to LOAD.
  - start is ignored in every other state.
- LOAD (1 cycle): clear both axis counters to their start values; busy=1; next state SCAN.
- SCAN: addr_valid=1.
  - While addr_valid && !addr_ready, x, y, line_last and frame_last hold stable.
  - On a handshake, the minor counter steps by one in its direction.
  - At the minor terminal value (0 when counting down, max when counting up), the minor counter reloads its start value and the major counter steps by one.
- line_last = minor counter at its terminal value.
- frame_last = line_last AND major counter at its terminal value.
- End of frame: a handshake with frame_last=1 moves to FIN.
  - The counters do not step on this handshake.
  - addr_valid drops in FIN.
- FIN (1 cycle): done=1, busy=1; next state IDLE with busy=0.
- First coordinate timing: the first coordinate is valid in the second cycle after start is sampled (start at cycle N gives LOAD at N+1 and addr_valid at N+2).
- Throughput: one coordinate per cycle while addr_ready=1.
  - Total handshakes per frame = IMG_W*IMG_H.
  - Start to done = IMG_W*IMG_H + 2 cycles minimum.
- Counter width: counters are CNT_W bits. Terminal detection is by explicit compare, so no counter wraps modulo 2**CNT_W.
- Abort:
  - In LOAD, SCAN or FIN, the next state is IDLE.
  - addr_valid, busy and done are 0 from the next cycle; no done pulse is produced.
  - Abort takes priority over a same-cycle handshake: the counters do not step.
- abort in IDLE has no effect.
- start and abort asserted together in IDLE: abort wins, and the FSM stays IDLE.
- reset mid-scan returns to the reset values on the next edge; reset overrides all inputs.
- Illegal values cannot occur, because orient is fully decoded across all 8 codes.

Decomposition:
- Package orient_scan_pkg holds:
  - The orient_e enum (O0, O45, O90, O135, O180, O225, O270, O315).
  - The state_e enum.
  - A struct {x_down, y_down, col_major}.
  - A function mapping orient_e to that struct.
- Sub-module scan_axis_cnt:
  - Ports: clk, reset, clear, enable, down, max_val, count, at_term.
  - Behaviour: an up/down counter whose clear loads 0 or max_val according to down.
  - Instantiated twice, once for x and once for y.

Test Plan:
- Bench parameters for all scenarios: IMG_W=4, IMG_H=3.
- Orient 0, addr_ready=1 → coordinates (0,0),(1,0),(2,0),(3,0),(0,1)...(3,2); line_last on every x=3; frame_last only on (3,2); done exactly 14 cycles after start.
- Orient 4 (180°) → (3,2),(2,2),(1,2),(0,2),(3,1)...(0,0); frame_last on (0,0).
- Orient 5 (225°) → column-major down: (3,2),(3,1),(3,0),(2,2)...(0,0); line_last on every y=0.
- Backpressure: orient 0 with addr_ready low for 3 cycles on the 2nd coordinate → (1,0) held stable for 4 cycles; sequence otherwise identical; done delayed by 3 cycles.
- Abort at the 5th coordinate (orient 2) → addr_valid=0 and busy=0 next cycle, no done; a fresh start then begins at (0,2).
- Start while busy and start+abort in IDLE → ignored and no transition, respectively; reset mid-SCAN → x=y=0 and all outputs low next cycle.
